// File: rtl/zanagotchi_pkg.sv
// ---------------------------------------------------------------------------
// zanagotchi_pkg
// Shared definitions for the zanagotchi attribute path:
//   - attribute indices used on the attribute controller's write port
//   - action encoding for the button-driven actions
//   - state encoding of the attribute write scheduler
//   - helpers that map an action onto its attribute and direction
// ---------------------------------------------------------------------------
package zanagotchi_pkg;

    localparam logic [1:0] ATR_FOME  = 2'd0;
    localparam logic [1:0] ATR_FELIC = 2'd1;
    localparam logic [1:0] ATR_SONO  = 2'd2;

    typedef enum logic [1:0] {
        ACAO_COMER   = 2'd0,
        ACAO_BRINCAR = 2'd1,
        ACAO_DORMIR  = 2'd2
    } acao_t;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        D_FOME  = 3'd1,
        D_FELIC = 3'd2,
        D_SONO  = 3'd3,
        ACAO    = 3'd4,
        MORTO   = 3'd5
    } estado_t;

    // Target attribute of an action.
    function automatic logic [1:0] acao_attr(input acao_t a);
        case (a)
            ACAO_COMER:   acao_attr = ATR_FOME;
            ACAO_BRINCAR: acao_attr = ATR_FELIC;
            default:      acao_attr = ATR_SONO;
        endcase
    endfunction

    // Direction of an action: eating lowers hunger, sleeping lowers
    // tiredness, playing raises happiness.
    function automatic logic acao_dec(input acao_t a);
        acao_dec = (a != ACAO_BRINCAR);
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// ---------------------------------------------------------------------------
// divisor_tick
// Free-running prescaler counting 0..TICK_CYCLES-1. tick is a registered
// one-cycle pulse raised on the edge where the counter wraps.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (counter to 0, tick low)
//   tick : one-cycle pulse per wrap
// ---------------------------------------------------------------------------
module divisor_tick #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(TICK_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/escalonador_atributos.sv
// ---------------------------------------------------------------------------
// escalonador_atributos
// Serialises every update to the attribute controller's single write port:
// the periodic decay (fome, felicidade, sono) and the button actions
// (comer, brincar, dormir). One command is issued at a time and held until
// wr_ack. A death flag parks the scheduler in MORTO until rst.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   morreu                   : death flag (level)
//   req_comer/brincar/dormir : one-cycle action request pulses
//   wr_en/attr/dec/amt       : registered write command, stable while wr_en
//   wr_ack                   : command accepted (only meaningful with wr_en)
//   busy                     : scheduler not idle
//   overrun (optional)       : saturating count of dropped decay ticks,
//                              present only with ESCALONADOR_OVERRUN_EN
// ---------------------------------------------------------------------------
module escalonador_atributos
    import zanagotchi_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int W           = 8,
    parameter int AMT_DECAY   = 1,
    parameter int AMT_ACAO    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         morreu,
    input  logic         req_comer,
    input  logic         req_brincar,
    input  logic         req_dormir,
    output logic         wr_en,
    output logic [1:0]   wr_attr,
    output logic         wr_dec,
    output logic [W-1:0] wr_amt,
    input  logic         wr_ack,
    output logic         busy
`ifdef ESCALONADOR_OVERRUN_EN
    ,
    output logic [7:0]   overrun
`endif
);

    logic           w_tick;
    estado_t        r_estado, w_estado_n;
    acao_t          r_acao, w_acao_n;
    logic           r_pend_tick, r_pend_comer, r_pend_brincar, r_pend_dormir;
    logic           w_clr_tick, w_clr_comer, w_clr_brincar, w_clr_dormir;
    logic           w_vivo, w_ack, w_tick_perdido;
    logic           r_wr_en, w_wr_en_n;
    logic [1:0]     r_wr_attr, w_wr_attr_n;
    logic           r_wr_dec, w_wr_dec_n;
    logic [W-1:0]   r_wr_amt, w_wr_amt_n;

    divisor_tick #(.TICK_CYCLES(TICK_CYCLES)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_ack  = r_wr_en & wr_ack;
    // Pending bits only accumulate while alive and not dying this cycle.
    assign w_vivo = !morreu && (r_estado != MORTO);
    // A wrap that finds a tick already pending is dropped, not queued.
    assign w_tick_perdido = w_tick && r_pend_tick && (r_estado != MORTO);

    // Next state, pending clears and the command for the next state.
    always_comb begin
        w_estado_n    = r_estado;
        w_acao_n      = r_acao;
        w_clr_tick    = 1'b0;
        w_clr_comer   = 1'b0;
        w_clr_brincar = 1'b0;
        w_clr_dormir  = 1'b0;

        if (morreu) begin
            // Abandons any in-flight command, even one acked this edge.
            w_estado_n = MORTO;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (r_pend_tick) begin
                        w_estado_n = D_FOME;
                        w_clr_tick = 1'b1;
                    end else if (r_pend_comer) begin
                        w_estado_n  = ACAO;
                        w_acao_n    = ACAO_COMER;
                        w_clr_comer = 1'b1;
                    end else if (r_pend_brincar) begin
                        w_estado_n    = ACAO;
                        w_acao_n      = ACAO_BRINCAR;
                        w_clr_brincar = 1'b1;
                    end else if (r_pend_dormir) begin
                        w_estado_n   = ACAO;
                        w_acao_n     = ACAO_DORMIR;
                        w_clr_dormir = 1'b1;
                    end
                end
                D_FOME:  if (w_ack) w_estado_n = D_FELIC;
                D_FELIC: if (w_ack) w_estado_n = D_SONO;
                D_SONO:  if (w_ack) w_estado_n = OCIOSO;
                ACAO:    if (w_ack) w_estado_n = OCIOSO;
                MORTO:   w_estado_n = MORTO;
                default: w_estado_n = OCIOSO;
            endcase
        end

        // Command fields are registered from the next state so they are
        // valid on the same edge that enters the command state.
        w_wr_en_n   = 1'b0;
        w_wr_attr_n = 2'd0;
        w_wr_dec_n  = 1'b0;
        w_wr_amt_n  = '0;
        case (w_estado_n)
            D_FOME: begin
                w_wr_en_n   = 1'b1;
                w_wr_attr_n = ATR_FOME;
                w_wr_amt_n  = W'(AMT_DECAY);
            end
            D_FELIC: begin
                w_wr_en_n   = 1'b1;
                w_wr_attr_n = ATR_FELIC;
                w_wr_dec_n  = 1'b1;
                w_wr_amt_n  = W'(AMT_DECAY);
            end
            D_SONO: begin
                w_wr_en_n   = 1'b1;
                w_wr_attr_n = ATR_SONO;
                w_wr_amt_n  = W'(AMT_DECAY);
            end
            ACAO: begin
                w_wr_en_n   = 1'b1;
                w_wr_attr_n = acao_attr(w_acao_n);
                w_wr_dec_n  = acao_dec(w_acao_n);
                w_wr_amt_n  = W'(AMT_ACAO);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= OCIOSO;
            r_acao    <= ACAO_COMER;
            r_wr_en   <= 1'b0;
            r_wr_attr <= 2'd0;
            r_wr_dec  <= 1'b0;
            r_wr_amt  <= '0;
        end else begin
            r_estado  <= w_estado_n;
            r_acao    <= w_acao_n;
            r_wr_en   <= w_wr_en_n;
            r_wr_attr <= w_wr_attr_n;
            r_wr_dec  <= w_wr_dec_n;
            r_wr_amt  <= w_wr_amt_n;
        end
    end

    // A request on the same edge its bit is cleared re-sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_tick    <= 1'b0;
            r_pend_comer   <= 1'b0;
            r_pend_brincar <= 1'b0;
            r_pend_dormir  <= 1'b0;
        end else begin
            r_pend_tick    <= w_vivo & (r_pend_tick ? !w_clr_tick : w_tick);
            r_pend_comer   <= w_vivo & ((r_pend_comer & !w_clr_comer) | req_comer);
            r_pend_brincar <= w_vivo & ((r_pend_brincar & !w_clr_brincar) | req_brincar);
            r_pend_dormir  <= w_vivo & ((r_pend_dormir & !w_clr_dormir) | req_dormir);
        end
    end

`ifdef ESCALONADOR_OVERRUN_EN
    logic [7:0] r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 8'd0;
        end else if (w_tick_perdido && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_perdido;
    assign w_unused_perdido = w_tick_perdido;
`endif

    assign wr_en   = r_wr_en;
    assign wr_attr = r_wr_attr;
    assign wr_dec  = r_wr_dec;
    assign wr_amt  = r_wr_amt;
    assign busy    = (r_estado != OCIOSO);

endmodule
